// File: rtl/qpu_cop2_sequencer.sv
// Captures a COP2 quantum instruction from the MIPS pipeline, stalls it, and issues one
// gate op to the gate engine. A MEASURE result returns as a one-cycle register write-back.
module qpu_cop2_sequencer #(
    parameter int NUM_QUBITS = 8,
    parameter int QADDR_W    = 3,
    parameter int TIMEOUT    = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               quantum_en,
    input  logic [31:0]        instr,
    output logic               stall,
    output logic               gate_valid,
    input  logic               gate_ready,
    output logic [2:0]         gate_op,
    output logic [QADDR_W-1:0] gate_qa,
    output logic [QADDR_W-1:0] gate_qb,
    output logic [10:0]        gate_param,
    input  logic               gate_done,
    input  logic               gate_meas,
    output logic               wb_en,
    output logic [4:0]         wb_addr,
    output logic [31:0]        wb_data,
    output logic               err
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        WB    = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam logic [4:0] OP_CNOT = 5'd3;
    localparam logic [4:0] OP_RZ   = 5'd4;
    localparam logic [4:0] OP_MEAS = 5'd5;
    localparam logic [4:0] OP_LAST = 5'd6;
    localparam logic [5:0] NQ      = 6'(NUM_QUBITS);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [25:0] ins;
    logic [7:0]  cnt;
    logic [4:0]  qop;
    logic [4:0]  qa;
    logic [4:0]  qb;
    logic        illegal;
    logic        unused_opcode;

    assign qop = ins[25:21];
    assign qa  = ins[20:16];
    assign qb  = ins[15:11];

    // The opcode was already decoded by the MIPS control unit; quantum_en carries that.
    assign unused_opcode = ^instr[31:26];

    assign illegal = (qop > OP_LAST)
                  || ({1'b0, qa} >= NQ)
                  || ((qop == OP_CNOT) && (({1'b0, qb} >= NQ) || (qb == qa)));

    assign stall = quantum_en | (state != IDLE);

    // Handshake: gate_valid rises with stable op/qa/qb/param and holds them unchanged
    // until the first cycle gate_valid & gate_ready are both high; that cycle is the accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ins        <= '0;
            cnt        <= '0;
            gate_valid <= 1'b0;
            gate_op    <= '0;
            gate_qa    <= '0;
            gate_qb    <= '0;
            gate_param <= '0;
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            err        <= 1'b0;
        end else begin
            wb_en <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (quantum_en) begin
                        ins   <= instr[25:0];
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (illegal) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        gate_valid <= 1'b1;
                        gate_op    <= qop[2:0];
                        gate_qa    <= qa[QADDR_W-1:0];
                        gate_qb    <= (qop == OP_CNOT) ? qb[QADDR_W-1:0] : '0;
                        gate_param <= (qop == OP_RZ) ? ins[10:0] : 11'd0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (gate_ready) begin
                        gate_valid <= 1'b0;
                        gate_op    <= '0;
                        gate_qa    <= '0;
                        gate_qb    <= '0;
                        gate_param <= '0;
                        cnt        <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // Completion is checked first so a done on the limit cycle still wins.
                    if (gate_done) begin
                        if (qop == OP_MEAS) begin
                            wb_en   <= 1'b1;
                            wb_addr <= qb;
                            wb_data <= {31'b0, gate_meas};
                            state   <= WB;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (cnt == TO_LAST) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WB: begin
                    wb_addr <= '0;
                    wb_data <= '0;
                    state   <= IDLE;
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qpu_cop2_sequencer.sv
// Directed bench for qpu_cop2_sequencer: gate issue, MEASURE write-back, backpressure,
// illegal fields, timeout, done-at-limit and asynchronous reset mid-instruction.
module tb_qpu_cop2_sequencer;
    logic        clk;
    logic        rst_n;
    logic        quantum_en;
    logic [31:0] instr;
    logic        stall;
    logic        gate_valid;
    logic        gate_ready;
    logic [2:0]  gate_op;
    logic [2:0]  gate_qa;
    logic [2:0]  gate_qb;
    logic [10:0] gate_param;
    logic        gate_done;
    logic        gate_meas;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err;

    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_wb = 0;
    int n_err = 0;
    int n_valid = 0;

    qpu_cop2_sequencer #(
        .NUM_QUBITS(8),
        .QADDR_W(3),
        .TIMEOUT(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .quantum_en(quantum_en),
        .instr(instr),
        .stall(stall),
        .gate_valid(gate_valid),
        .gate_ready(gate_ready),
        .gate_op(gate_op),
        .gate_qa(gate_qa),
        .gate_qb(gate_qb),
        .gate_param(gate_param),
        .gate_done(gate_done),
        .gate_meas(gate_meas),
        .wb_en(wb_en),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .err(err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // event counters sampled at the active edge
    always @(posedge clk) begin
        if (gate_valid && gate_ready) n_acc <= n_acc + 1;
        if (gate_valid) n_valid <= n_valid + 1;
        if (wb_en) n_wb <= n_wb + 1;
        if (err) n_err <= n_err + 1;
    end

    // a new instruction may only be presented while the sequencer is idle
    always @(posedge clk) begin
        if (rst_n && quantum_en && (dut.state != 3'd0))
            $error("FAIL quantum_en_while_busy state %0d", dut.state);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [60:0] obs;
        rst_n = 1'b1;
        quantum_en = 1'b0;
        instr = '0;
        gate_ready = 1'b0;
        gate_done = 1'b0;
        gate_meas = 1'b0;
        #1 rst_n = 1'b0;
        #11;
        obs = {stall, gate_valid, gate_op, gate_qa, gate_qb, gate_param, wb_en, wb_addr, wb_data, err};
        checks++;
        if (obs !== 61'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", obs);
        end
        tick;
        rst_n = 1'b1;
        tick;
        checks++;
        if ({stall, gate_valid, wb_en, err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_release got %b exp 0000", {stall, gate_valid, wb_en, err});
        end
    endtask

    task automatic test_single_gate;
        int ba, bw, be;
        ba = n_acc; bw = n_wb; be = n_err;
        quantum_en = 1'b1;
        instr = {6'h12, 5'd0, 5'd2, 5'd0, 11'd0};
        gate_ready = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL h_stall_capture got %b exp 1", stall);
        end
        tick;
        quantum_en = 1'b0;
        instr = '0;
        tick;
        checks++;
        if ({gate_valid, gate_op, gate_qa, gate_qb, gate_param} !== {1'b1, 3'd0, 3'd2, 3'd0, 11'd0}) begin
            errors++;
            $display("FAIL h_issue got %b %0d %0d %0d %h exp 1 0 2 0 000",
                     gate_valid, gate_op, gate_qa, gate_qb, gate_param);
        end
        tick;
        gate_ready = 1'b0;
        checks++;
        if (gate_valid !== 1'b0) begin
            errors++;
            $display("FAIL h_valid_drop got %b exp 0", gate_valid);
        end
        tick;
        tick;
        gate_done = 1'b1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL h_stall_wait got %b exp 1", stall);
        end
        tick;
        gate_done = 1'b0;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL h_stall_drop got %b exp 0", stall);
        end
        checks++;
        if ((n_acc - ba) != 1 || (n_wb - bw) != 0 || (n_err - be) != 0) begin
            errors++;
            $display("FAIL h_events got acc %0d wb %0d err %0d exp 1 0 0",
                     n_acc - ba, n_wb - bw, n_err - be);
        end
    endtask

    task automatic test_measure;
        int bw;
        bw = n_wb;
        quantum_en = 1'b1;
        instr = {6'h12, 5'd5, 5'd5, 5'd9, 11'd0};
        gate_ready = 1'b1;
        tick;
        quantum_en = 1'b0;
        instr = '0;
        tick;
        tick;
        gate_ready = 1'b0;
        gate_done = 1'b1;
        gate_meas = 1'b1;
        checks++;
        if (wb_en !== 1'b0) begin
            errors++;
            $display("FAIL meas_early_wb got %b exp 0", wb_en);
        end
        tick;
        gate_done = 1'b0;
        gate_meas = 1'b0;
        checks++;
        if ({wb_en, wb_addr, wb_data, stall} !== {1'b1, 5'd9, 32'h1, 1'b1}) begin
            errors++;
            $display("FAIL meas_wb got en %b addr %0d data %h stall %b exp 1 9 00000001 1",
                     wb_en, wb_addr, wb_data, stall);
        end
        tick;
        checks++;
        if ({wb_en, stall} !== 2'b00) begin
            errors++;
            $display("FAIL meas_after got en %b stall %b exp 0 0", wb_en, stall);
        end
        checks++;
        if ((n_wb - bw) != 1) begin
            errors++;
            $display("FAIL meas_wb_count got %0d exp 1", n_wb - bw);
        end
    endtask

    task automatic test_backpressure;
        int ba;
        ba = n_acc;
        quantum_en = 1'b1;
        instr = {6'h12, 5'd3, 5'd1, 5'd4, 11'h5A5};
        gate_ready = 1'b0;
        tick;
        quantum_en = 1'b0;
        instr = '0;
        tick;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({gate_valid, gate_op, gate_qa, gate_qb, gate_param} !== {1'b1, 3'd3, 3'd1, 3'd4, 11'd0}) begin
                errors++;
                $display("FAIL bp_hold[%0d] got %b %0d %0d %0d %h exp 1 3 1 4 000",
                         i, gate_valid, gate_op, gate_qa, gate_qb, gate_param);
            end
            tick;
        end
        gate_ready = 1'b1;
        tick;
        gate_ready = 1'b0;
        checks++;
        if (gate_valid !== 1'b0 || (n_acc - ba) != 1) begin
            errors++;
            $display("FAIL bp_accept got valid %b acc %0d exp 0 1", gate_valid, n_acc - ba);
        end
        gate_done = 1'b1;
        tick;
        gate_done = 1'b0;
        checks++;
        if ({stall, wb_en, err} !== 3'b000) begin
            errors++;
            $display("FAIL bp_done got %b exp 000", {stall, wb_en, err});
        end
    endtask

    task automatic test_illegal;
        logic [31:0] vec [3];
        int bv, be;
        vec[0] = {6'h12, 5'd7, 5'd0, 5'd0, 11'd0};
        vec[1] = {6'h12, 5'd0, 5'd8, 5'd0, 11'd0};
        vec[2] = {6'h12, 5'd3, 5'd3, 5'd3, 11'd0};
        gate_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bv = n_valid; be = n_err;
            quantum_en = 1'b1;
            instr = vec[i];
            tick;
            quantum_en = 1'b0;
            instr = '0;
            tick;
            checks++;
            if ({err, gate_valid, stall} !== 3'b101) begin
                errors++;
                $display("FAIL illegal_err[%0d] got %b exp 101", i, {err, gate_valid, stall});
            end
            tick;
            checks++;
            if ({err, stall} !== 2'b00 || (n_valid - bv) != 0 || (n_err - be) != 1) begin
                errors++;
                $display("FAIL illegal_after[%0d] got err %b stall %b valid %0d errs %0d exp 0 0 0 1",
                         i, err, stall, n_valid - bv, n_err - be);
            end
        end
        gate_ready = 1'b0;
    endtask

    task automatic test_legal_boundaries;
        logic [31:0] vec [2];
        logic [19:0] exp [2];
        vec[0] = {6'h12, 5'd4, 5'd7, 5'd6, 11'h3FF};
        exp[0] = {3'd4, 3'd7, 3'd0, 11'h3FF};
        vec[1] = {6'h12, 5'd6, 5'd0, 5'd2, 11'h123};
        exp[1] = {3'd6, 3'd0, 3'd0, 11'd0};
        gate_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            quantum_en = 1'b1;
            instr = vec[i];
            tick;
            quantum_en = 1'b0;
            instr = '0;
            tick;
            checks++;
            if ({gate_valid, gate_op, gate_qa, gate_qb, gate_param} !== {1'b1, exp[i]}) begin
                errors++;
                $display("FAIL legal_issue[%0d] got %b %0d %0d %0d %h exp 1 %h",
                         i, gate_valid, gate_op, gate_qa, gate_qb, gate_param, exp[i]);
            end
            tick;
            gate_done = 1'b1;
            tick;
            gate_done = 1'b0;
            checks++;
            if ({stall, wb_en, err} !== 3'b000) begin
                errors++;
                $display("FAIL legal_done[%0d] got %b exp 000", i, {stall, wb_en, err});
            end
        end
        gate_ready = 1'b0;
    endtask

    task automatic test_done_in_idle;
        int bw;
        bw = n_wb;
        gate_done = 1'b1;
        gate_meas = 1'b1;
        tick;
        gate_done = 1'b0;
        gate_meas = 1'b0;
        tick;
        checks++;
        if (stall !== 1'b0 || (n_wb - bw) != 0) begin
            errors++;
            $display("FAIL idle_done got stall %b wb %0d exp 0 0", stall, n_wb - bw);
        end
    endtask

    task automatic test_timeout;
        int be;
        be = n_err;
        quantum_en = 1'b1;
        instr = {6'h12, 5'd1, 5'd0, 5'd0, 11'd0};
        gate_ready = 1'b1;
        tick;
        quantum_en = 1'b0;
        instr = '0;
        tick;
        tick;
        gate_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick;
            checks++;
            if ({err, stall} !== 2'b01) begin
                errors++;
                $display("FAIL to_wait[%0d] got %b exp 01", k, {err, stall});
            end
        end
        tick;
        checks++;
        if ({err, stall} !== 2'b11) begin
            errors++;
            $display("FAIL to_err got %b exp 11", {err, stall});
        end
        tick;
        checks++;
        if ({err, stall} !== 2'b00 || (n_err - be) != 1) begin
            errors++;
            $display("FAIL to_after got %b errs %0d exp 00 1", {err, stall}, n_err - be);
        end
    endtask

    task automatic test_done_at_limit;
        int be;
        be = n_err;
        quantum_en = 1'b1;
        instr = {6'h12, 5'd2, 5'd3, 5'd0, 11'd0};
        gate_ready = 1'b1;
        tick;
        quantum_en = 1'b0;
        instr = '0;
        tick;
        tick;
        gate_ready = 1'b0;
        repeat (9) tick;
        gate_done = 1'b1;
        tick;
        gate_done = 1'b0;
        checks++;
        if ({err, stall} !== 2'b00 || (n_err - be) != 0) begin
            errors++;
            $display("FAIL limit_done_wins got %b errs %0d exp 00 0", {err, stall}, n_err - be);
        end
    endtask

    task automatic test_reset_in_wait;
        int bw, ba;
        bw = n_wb;
        quantum_en = 1'b1;
        instr = {6'h12, 5'd5, 5'd5, 5'd9, 11'd0};
        gate_ready = 1'b1;
        tick;
        quantum_en = 1'b0;
        instr = '0;
        tick;
        tick;
        gate_ready = 1'b0;
        tick;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({stall, gate_valid, wb_en, wb_addr, wb_data, err} !== 41'd0) begin
            errors++;
            $display("FAIL rst_async got stall %b valid %b wb %b addr %0d data %h err %b exp all 0",
                     stall, gate_valid, wb_en, wb_addr, wb_data, err);
        end
        gate_done = 1'b1;
        gate_meas = 1'b1;
        tick;
        gate_done = 1'b0;
        gate_meas = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick;
        checks++;
        if (stall !== 1'b0 || (n_wb - bw) != 0) begin
            errors++;
            $display("FAIL rst_no_wb got stall %b wb %0d exp 0 0", stall, n_wb - bw);
        end
        ba = n_acc;
        quantum_en = 1'b1;
        instr = {6'h12, 5'd0, 5'd6, 5'd0, 11'd0};
        gate_ready = 1'b1;
        tick;
        quantum_en = 1'b0;
        instr = '0;
        tick;
        checks++;
        if ({gate_valid, gate_op, gate_qa} !== {1'b1, 3'd0, 3'd6}) begin
            errors++;
            $display("FAIL rst_next_issue got %b %0d %0d exp 1 0 6", gate_valid, gate_op, gate_qa);
        end
        tick;
        gate_ready = 1'b0;
        gate_done = 1'b1;
        tick;
        gate_done = 1'b0;
        checks++;
        if ({stall, wb_en, err} !== 3'b000 || (n_acc - ba) != 1) begin
            errors++;
            $display("FAIL rst_next_done got %b acc %0d exp 000 1", {stall, wb_en, err}, n_acc - ba);
        end
    endtask

    initial begin
        test_reset;
        test_single_gate;
        tick;
        test_measure;
        test_backpressure;
        test_illegal;
        test_legal_boundaries;
        test_done_in_idle;
        test_timeout;
        test_done_at_limit;
        test_reset_in_wait;
        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
